// File: rtl/disp_pkg.sv
// Shared constants and types for the display-ownership scheduler.
package disp_pkg;

    localparam int NREQ  = 3;
    localparam int TMR_W = 25;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Requester indices wrap 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/disp_sched_if.sv
// Requester-side and display-side signal bundle of the display scheduler.
interface disp_sched_if;
    import disp_pkg::*;

    logic [NREQ-1:0] req;
    logic [15:0]     dig0, dig1, dig2;
    logic [3:0]      dpi0, dpi1, dpi2;
    logic [NREQ-1:0] gnt;
    logic [3:0]      hex3, hex2, hex1, hex0;
    logic [3:0]      dp_out;
    logic            busy;

    modport master (
        output req, dig0, dig1, dig2, dpi0, dpi1, dpi2,
        input  gnt, hex3, hex2, hex1, hex0, dp_out, busy
    );

    modport slave (
        input  req, dig0, dig1, dig2, dpi0, dpi1, dpi2,
        output gnt, hex3, hex2, hex1, hex0, dp_out, busy
    );

endinterface

// File: rtl/disp_rr_pick.sv
// Combinational round-robin search: first set req bit at start, start+1, start+2 (mod 3).
module disp_rr_pick
    import disp_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      start,
    output logic            found,
    output logic [1:0]      index
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        index = start;
        cand  = start;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Arbitrates three requesters for one 4-digit 7-seg display with a minimum hold time
// and round-robin rotation; all display-side outputs are registered.
module disp_sched
    import disp_pkg::*;
#(
    parameter int HOLD_CYC = 25_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    disp_sched_if.slave  bus
);

    localparam logic [TMR_W-1:0] TC = TMR_W'(HOLD_CYC - 1);

    state_t            state, state_nx;
    logic [1:0]        owner, owner_nx;
    logic [1:0]        last_owner, last_nx;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic              expired;

    logic [NREQ-1:0]   own_mask;
    logic [NREQ-1:0]   pick_req;
    logic              pick_found;
    logic [1:0]        pick_idx;

    logic [NREQ-1:0]   gnt_q, gnt_nx;
    logic [15:0]       hex_q, hex_nx;
    logic [3:0]        dp_q, dp_nx;

    assign expired  = (timer == TC);
    assign own_mask = NREQ'(1) << owner;
    // While owning, last_owner == owner, so one search serves both states once the
    // current owner is masked out of the candidates.
    assign pick_req = (state == OWN) ? (bus.req & ~own_mask) : bus.req;

    disp_rr_pick u_pick (
        .req   (pick_req),
        .start (rr_next(last_owner)),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_owner;
        timer_nx = timer;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = OWN;
                    owner_nx = pick_idx;
                    last_nx  = pick_idx;
                    timer_nx = '0;
                end
            end
            OWN: begin
                if (!bus.req[owner] || (expired && pick_found)) begin
                    timer_nx = '0;
                    if (pick_found) begin
                        owner_nx = pick_idx;
                        last_nx  = pick_idx;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (!expired) begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_nx = '0;
        hex_nx = 16'h0000;
        dp_nx  = 4'b0000;
        if (state_nx == OWN) begin
            gnt_nx = NREQ'(1) << owner_nx;
            case (owner_nx)
                2'd0:    begin hex_nx = bus.dig0; dp_nx = bus.dpi0; end
                2'd1:    begin hex_nx = bus.dig1; dp_nx = bus.dpi1; end
                default: begin hex_nx = bus.dig2; dp_nx = bus.dpi2; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            timer      <= '0;
            gnt_q      <= '0;
            hex_q      <= 16'h0000;
            dp_q       <= 4'b0000;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            timer      <= timer_nx;
            gnt_q      <= gnt_nx;
            hex_q      <= hex_nx;
            dp_q       <= dp_nx;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = |gnt_q;
    assign bus.hex3   = hex_q[15:12];
    assign bus.hex2   = hex_q[11:8];
    assign bus.hex1   = hex_q[7:4];
    assign bus.hex0   = hex_q[3:0];
    assign bus.dp_out = dp_q;

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched (HOLD_CYC=4): a queue-based ownership model predicts
// every cycle's outputs; directed scenarios plus randomized request traffic.
module tb_disp_sched;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset_n;

    disp_sched_if bus();

    disp_sched #(.HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  gnt;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: owner -1 means nobody owns; shown counts cycles the owner has displayed.
    int          m_owner = -1;
    int          m_last  = 2;
    int          m_shown = 0;
    logic [15:0] dg[3];
    logic [3:0]  dpv[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int from);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (from + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 2;
        m_shown = 0;
    endtask

    task automatic model_step(input logic [2:0] r);
        exp_t x;
        logic [2:0] others;
        int nxt;
        if (m_owner < 0) begin
            nxt = pick(r, m_last);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_last  = nxt;
                m_shown = 0;
            end
        end else begin
            m_shown++;
            others = r & ~(3'b001 << m_owner);
            nxt = pick(others, m_owner);
            if (!r[m_owner]) begin
                m_owner = nxt;
                if (nxt >= 0) begin
                    m_last  = nxt;
                    m_shown = 0;
                end
            end else if (m_shown >= HOLD && nxt >= 0) begin
                m_owner = nxt;
                m_last  = nxt;
                m_shown = 0;
            end
        end
        if (m_owner >= 0) begin
            x.gnt = 3'b001 << m_owner;
            x.hex = dg[m_owner];
            x.dp  = dpv[m_owner];
        end else begin
            x.gnt = 3'b000;
            x.hex = 16'h0000;
            x.dp  = 4'b0000;
        end
        x.busy = (x.gnt != 3'b000);
        sb.push_back(x);
    endtask

    task automatic drive(input logic [2:0] r);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dg[i]  = 16'($urandom);
            dpv[i] = 4'($urandom);
        end
        bus.req  = r;
        bus.dig0 = dg[0];
        bus.dig1 = dg[1];
        bus.dig2 = dg[2];
        bus.dpi0 = dpv[0];
        bus.dpi1 = dpv[1];
        bus.dpi2 = dpv[2];
        model_step(r);
    endtask

    task automatic drive_chk(input logic [2:0] r, input logic [2:0] exp_gnt, input string name);
        drive(r);
        @(posedge clk);
        #2;
        chk(name, 32'(bus.gnt), 32'(exp_gnt));
    endtask

    // Monitor: the DUT presents a new display state every cycle.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("gnt",    32'(bus.gnt), 32'(e.gnt));
            chk("hex",    32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(e.hex));
            chk("dp_out", 32'(bus.dp_out), 32'(e.dp));
            chk("busy",   32'(bus.busy), 32'(e.busy));
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] r;
        reset_n  = 1'b0;
        bus.req  = 3'b000;
        bus.dig0 = 16'h0;
        bus.dig1 = 16'h0;
        bus.dig2 = 16'h0;
        bus.dpi0 = 4'h0;
        bus.dpi1 = 4'h0;
        bus.dpi2 = 4'h0;
        #12;
        chk("rst_gnt",  32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hex",  32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'd0);
        chk("rst_dp",   32'(bus.dp_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // All request: 001 x4, 010 x4, 100 x4, then back to 001.
        for (int i = 0; i < 13; i++)
            drive_chk(3'b111, 3'b001 << ((i / HOLD) % 3), "rr_rotate");

        drive_chk(3'b000, 3'b000, "all_drop");

        // Owner 0 is not preempted by requester 2 before the hold time elapses.
        drive_chk(3'b001, 3'b001, "own0_grant");
        for (int i = 0; i < HOLD - 1; i++)
            drive_chk(3'b101, 3'b001, "no_preempt");
        drive_chk(3'b101, 3'b100, "expire_rotate");

        // Owner 2 drops -> 1; owner 1 drops at cycle 1 -> 0 with a fresh timer.
        drive_chk(3'b010, 3'b010, "own1_grant");
        drive_chk(3'b011, 3'b010, "own1_cyc1");
        drive_chk(3'b001, 3'b001, "drop_handover");
        for (int i = 0; i < HOLD - 1; i++)
            drive_chk(3'b011, 3'b001, "timer_cleared");
        drive_chk(3'b011, 3'b010, "timer_cleared_rot");

        // Asynchronous reset while requester 1 owns the display.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_gnt",  32'(bus.gnt), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive_chk(3'b110, 3'b010, "post_rst_grant");

        // Sole requester keeps ownership indefinitely.
        for (int i = 0; i < 10; i++)
            drive(3'b010);

        // Randomized level-held request traffic.
        r = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom);
            drive(r);
        end

        @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter HOLD_CYC, default 25_000_000, SHALL set the minimum ownership time in clk cycles (0.5 s at 50 MHz); legal range 2..2^25-1.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req  input  3  SHALL carry one display request per requester; req[0..2] are independent, level-held.
REQ-005 dig0, dig1, dig2  input  16 each  SHALL be requester n's four hex digits, [15:12]=digit3 ... [3:0]=digit0.
REQ-006 dpi0, dpi1, dpi2  input  4 each  SHALL be requester n's four decimal-point bits, bit k = digit k.
REQ-007 gnt  output  3  SHALL be one-hot or zero; gnt[n]=1 means requester n owns the display.
REQ-008 hex3, hex2, hex1, hex0  output  4 each  SHALL drive the 7-seg multiplexer digit inputs.
REQ-009 dp_out  output  4  SHALL drive the multiplexer decimal-point inputs.
REQ-010 busy  output  1  SHALL be 1 whenever any gnt bit is 1.

Function
REQ-011 FSM states SHALL be IDLE (no owner) and OWN (owner register valid); owner is a 2-bit index 0..2.
REQ-012 IDLE: if any req bit is 1, the FSM SHALL grant the first requesting index in round-robin order after last_owner, enter OWN and clear the hold timer.
REQ-013 OWN: the hold timer SHALL increment each cycle, saturate at HOLD_CYC-1, and raise expired when it equals HOLD_CYC-1.
REQ-014 OWN, owner's req drops: the FSM SHALL release next cycle regardless of timer; if another req is high, grant it directly (OWN->OWN, timer cleared), otherwise go to IDLE.
REQ-015 OWN, owner's req high, expired=1, another req high: the FSM SHALL rotate to the next requesting index in round-robin order and clear the timer.
REQ-016 OWN, owner's req high, expired=0: no other requester SHALL preempt, regardless of index.
REQ-017 OWN, owner sole requester: ownership SHALL persist indefinitely with the timer saturated.
REQ-018 Round-robin order SHALL be owner+1, owner+2 (mod 3); last_owner SHALL update on every grant.
REQ-019 gnt, hex*, dp_out and busy SHALL be registered; they SHALL reflect a grant decision one cycle after the req edge that caused it.
REQ-020 While owning, hex*/dp_out SHALL track the owner's dig/dpi live with one cycle latency.
REQ-021 In IDLE, hex3..hex0 SHALL be 4'h0 and dp_out 4'b0000.
REQ-022 gnt SHALL never have more than one bit set, and SHALL never stay zero in a cycle after a cycle with any req high, except directly after reset.

Reset
REQ-023 While reset_n=0: state=IDLE, owner=0, last_owner=2 (first grant favours requester 0), timer=0, gnt=3'b000, busy=0, hex*=4'h0, dp_out=4'b0000.
REQ-024 Reset asserted mid-ownership SHALL drop gnt asynchronously; after release, arbitration SHALL restart from the REQ-023 values.

Structure
REQ-025 Shared package disp_pkg SHALL hold NREQ=3, the IDLE/OWN state encoding and the timer width constant (25).
REQ-026 The next-owner round-robin search SHALL be a sub-module disp_rr_pick (inputs req, start index; outputs found, index), purely combinational.

Verification (bench HOLD_CYC=4)
REQ-027 After reset, req=3'b111 -> gnt=3'b001 one cycle later; hex/dp = dig0/dpi0.
REQ-028 req held 3'b111 -> gnt sequence 001 (4 cycles), 010 (4), 100 (4), 001 ...
REQ-029 Owner 0 with req=3'b001, req[2] rises at cycle 1 of ownership -> gnt stays 001 until timer expires, then 100.
REQ-030 Owner 1, req[1] drops at cycle 1 with req[0]=1 -> gnt=001 next cycle, timer cleared.
REQ-031 All req drop -> next cycle gnt=000, busy=0, hex=0000, dp_out=0000.
REQ-032 reset_n pulsed low while gnt=010 -> gnt=000 immediately; after release, req=3'b110 -> gnt=010.
